// File: rtl/cdc_handshake_tx.sv
// Source-side controller for a 4-phase req/ack bundled-data clock-domain crossing.
// Define CDC_HS_TIMEOUT_EN to build the REQ-phase ack timeout and err pulse.
module cdc_handshake_tx #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack_async,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [SYNC_STAGES-1:0] primed_q;
    logic                   ack_s;

    // primed_q fills with ones as the sync chain refills with real ack samples after reset,
    // so a stale ack held across reset is seen before a word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync_q <= '0;
            primed_q   <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_async};
            primed_q   <= {primed_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

`ifdef CDC_HS_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign err = err_q;
`else
    // TIMEOUT_CYCLES has no effect in this build.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        abort_d = abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    state_d = REQ;
`ifdef CDC_HS_TIMEOUT_EN
                    cnt_d   = '0;
                    abort_d = 1'b0;
`endif
                end
            end
            REQ: begin
                // Ack is checked first so it wins over a timeout expiring on the same cycle.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
`ifdef CDC_HS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE: begin
                if (!ack_s) begin
`ifdef CDC_HS_TIMEOUT_EN
                    done_d  = !abort_q;
`else
                    done_d  = 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = !rst && (state_q == IDLE) && !ack_s && primed_q[SYNC_STAGES-1];
    assign busy      = (state_q != IDLE);
    assign xfer_req  = req_q;
    assign xfer_data = data_q;
    assign done      = done_q;

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side controller for a 4-phase req/ack bundled-data clock-domain crossing. Accepts a WIDTH-bit word on a valid/ready interface, holds it stable on `xfer_data`, and drives `xfer_req` through both handshake phases. It synchronizes the returning asynchronous `xfer_ack_async` internally with a SYNC_STAGES flop chain. It sits in the source clock domain in front of a destination-side receiver that captures `xfer_data` once its own synchronized copy of `xfer_req` goes high.

## Interface
- WIDTH, 8: payload width in bits, ≥1.
- SYNC_STAGES, 2: flop stages on the ack synchronizer, ≥2.
- TIMEOUT_CYCLES, 1024: cycles allowed in REQ before abort, ≥1. Used only with CDC_HS_TIMEOUT_EN.

- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  upstream word.
- xfer_req  out  1  registered request to the destination domain.
- xfer_data  out  WIDTH  registered payload, stable for the whole handshake.
- xfer_ack_async  in  1  acknowledge from the destination domain; asynchronous to `clk`.
- done  out  1  one-cycle pulse when a transfer completes successfully.
- err  out  1  one-cycle pulse on timeout abort. Tied 0 without the macro.
- busy  out  1  high when the state is not IDLE.

## Operation
- `ack_s` is `xfer_ack_async` passed through SYNC_STAGES flops, all cleared by `rst`.
- States:
  - **IDLE:** `in_ready = !ack_s`. On `in_valid && in_ready`, capture `in_data` into `xfer_data`, set `xfer_req <= 1`, and go to REQ.
  - **REQ:** hold `xfer_req = 1`. On `ack_s == 1`, set `xfer_req <= 0` and go to RELEASE.
  - **RELEASE:** `xfer_req = 0`. On `ack_s == 0`, pulse `done` and go to IDLE.
- `in_ready` is 0 in REQ and RELEASE, while `rst` is high, and in IDLE while `ack_s` is high (stale ack after reset or abort).
- `xfer_data` changes only on acceptance. It never changes while `xfer_req` is high or while the state is RELEASE.
- `busy = (state != IDLE)`.
- Reset values: state IDLE, `xfer_req` 0, `xfer_data` 0, `done` 0, `err` 0, synchronizer flops 0, timeout counter 0.
- Reset asserted mid-handshake drops `xfer_req` on the next edge. No `done` or `err` pulse is generated. The destination side must tolerate an abandoned request.
- `in_valid` arriving while not ready is ignored. The block has no internal buffer, so upstream holds the word.

## Timing
- `xfer_req` rises on the edge after acceptance.
- With the bench looping `xfer_req` straight back to `xfer_ack_async`, one transfer takes 2·(SYNC_STAGES+1)+1 cycles from accept edge to next possible accept edge. That is 7 cycles for SYNC_STAGES = 2:
  - E0: accept.
  - E2: `ack_s` = 1.
  - E3: `xfer_req` falls.
  - E5: `ack_s` = 0.
  - E6: enter IDLE and pulse `done`.
  - E7: next accept.
- `done` is high for exactly the one cycle following the edge that enters IDLE from RELEASE.
- `ack_s` lags `xfer_ack_async` by SYNC_STAGES edges. Glitches shorter than one `clk` period may be missed, and the FSM must not depend on seeing them.

## Configuration
- Macro `CDC_HS_TIMEOUT_EN`.
- **Defined:**
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and increments each cycle in REQ.
  - If it reaches TIMEOUT_CYCLES with `ack_s` still 0, `err` pulses for one cycle, `xfer_req <= 0`, and the state goes to RELEASE. No `done` pulse follows for that word.
  - If `ack_s` rises on the same cycle the count expires, ack wins and no `err` pulse is generated.
- **Undefined:** no counter is built, REQ waits indefinitely, and `err` is constant 0.

## Test plan
- Reset, then loopback ack with SYNC_STAGES = 2; send 0xA5 → `xfer_data` = 0xA5 from E0 until return to IDLE, `xfer_req` high for E1..E3, `done` pulse at E6+1, `in_ready` back at E7.
- Back-to-back `in_valid` with words 0x01..0x04 under loopback → exactly 4 `done` pulses 7 cycles apart; words appear in order on `xfer_data`; `xfer_data` never changes while `xfer_req` = 1.
- Ack held at 1 before and through reset release → `in_ready` stays 0 until SYNC_STAGES cycles after ack drops; no spurious `xfer_req`.
- `rst` pulsed while in REQ → `xfer_req` = 0 on the next edge, state IDLE, no `done` or `err`; a new transfer afterward completes normally.
- With `CDC_HS_TIMEOUT_EN` defined, TIMEOUT_CYCLES = 8, ack held 0 → `err` pulses 8 cycles after REQ entry, `xfer_req` falls, block returns to IDLE once `ack_s` = 0, no `done`.
- Random ack delay of 0..20 cycles per phase over 200 words → count of `done` pulses equals count of accepted words; `xfer_data` stability holds throughout.
